// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one RV32IM multiplier between two requesters.
// Latches the winner's operands, holds them on the multiplier until it finishes
// or the watchdog fires, then strobes the result back to the winner.
module mult_arbiter #(
  parameter int unsigned LENGTH  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID_0,
  input  logic              REQ_VALID_1,
  output logic              REQ_READY_0,
  output logic              REQ_READY_1,
  input  logic [LENGTH-1:0] REQ_A_0,
  input  logic [LENGTH-1:0] REQ_A_1,
  input  logic [LENGTH-1:0] REQ_B_0,
  input  logic [LENGTH-1:0] REQ_B_1,
  input  logic              REQ_FUCT3_0,
  input  logic              REQ_FUCT3_1,
  output logic              RSP_VALID_0,
  output logic              RSP_VALID_1,
  output logic [LENGTH-1:0] RSP_DATA,
  output logic              RSP_ERR,
  output logic [LENGTH-1:0] OPER_A,
  output logic [LENGTH-1:0] OPER_B,
  output logic              ENABLE_MULT,
  output logic              FUCT3,
  input  logic [LENGTH-1:0] MULT_O,
  input  logic              MULT_FINISH
);

  localparam int unsigned CNT_W  = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned CNT_W1 = CNT_W + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  state_t           state_nx;
  logic             last;
  logic             grant_id;
  logic             win;
  logic             accept;
  logic             finish_hit;
  logic             timeout_hit;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cnt_inc;

  // Counter value this BUSY cycle will have reached once it is counted.
  assign cnt_inc = {1'b0, cnt} + CNT_W1'(1);

  // Next-state, arbitration and combinational handshake.
  always_comb begin
    state_nx    = state;
    accept      = 1'b0;
    win         = 1'b0;
    finish_hit  = 1'b0;
    timeout_hit = 1'b0;
    REQ_READY_0 = 1'b0;
    REQ_READY_1 = 1'b0;
    case (state)
      IDLE: begin
        if (!RST && (REQ_VALID_0 || REQ_VALID_1)) begin
          accept      = 1'b1;
          win         = (REQ_VALID_0 && REQ_VALID_1) ? ~last : REQ_VALID_1;
          REQ_READY_0 = ~win;
          REQ_READY_1 = win;
          state_nx    = BUSY;
        end
      end
      BUSY: begin
        if (MULT_FINISH) begin
          finish_hit = 1'b1;
          state_nx   = DONE;
        end else if ((TIMEOUT != 0) && (cnt_inc == CNT_W1'(TIMEOUT))) begin
          timeout_hit = 1'b1;
          state_nx    = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, operand latches, watchdog and registered response outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      last        <= 1'b1;
      grant_id    <= 1'b0;
      cnt         <= '0;
      OPER_A      <= '0;
      OPER_B      <= '0;
      FUCT3       <= 1'b0;
      ENABLE_MULT <= 1'b0;
      RSP_VALID_0 <= 1'b0;
      RSP_VALID_1 <= 1'b0;
      RSP_DATA    <= '0;
      RSP_ERR     <= 1'b0;
    end else begin
      state       <= state_nx;
      ENABLE_MULT <= (state_nx == BUSY);
      RSP_VALID_0 <= (state_nx == DONE) && !grant_id;
      RSP_VALID_1 <= (state_nx == DONE) && grant_id;
      cnt         <= (state == BUSY) ? cnt + CNT_W'(1) : '0;
      if (accept) begin
        OPER_A   <= win ? REQ_A_1 : REQ_A_0;
        OPER_B   <= win ? REQ_B_1 : REQ_B_0;
        FUCT3    <= win ? REQ_FUCT3_1 : REQ_FUCT3_0;
        grant_id <= win;
        last     <= win;
      end
      if (finish_hit) begin
        RSP_DATA <= MULT_O;
        RSP_ERR  <= 1'b0;
      end else if (timeout_hit) begin
        RSP_DATA <= '0;
        RSP_ERR  <= 1'b1;
      end
    end
  end

endmodule
